// File: rtl/result_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : result_decoder
//  Purpose  : Receive-side demultiplexer for the shared dice / traffic-light
//             result bus. Splits the bus by `sel`, debounces and validates
//             dice throws (1..6), tracks the light sequence
//             red -> red+amber -> green -> amber -> red, and counts protocol
//             violations in a saturating counter.
//  Ports    : clk            - rising-edge clock
//             rst            - asynchronous active-low reset
//             result[2:0]    - muxed bus (dice value, or {red,amber,green})
//             sel            - channel select (0 = dice, 1 = lights)
//             dice_value     - last accepted throw
//             dice_strobe    - 1-clock pulse when dice_value updates
//             dice_error     - 1-clock pulse on a stable illegal throw
//             lights         - tracked {red,amber,green}, 000 while unlocked
//             lights_locked  - light tracker synchronised
//             seq_error      - 1-clock pulse on illegal pattern/transition
//             error_count    - saturating count of error pulses
//             seg[6:0]       - {g,f,e,d,c,b,a} of dice_value (optional)
//  Options  : RESULT_DECODER_SEG_EN - adds the registered seg output
//  Revision : 1.0 - initial release
// ============================================================================
module result_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       result,
    input  logic             sel,
    output logic [2:0]       dice_value,
    output logic             dice_strobe,
    output logic             dice_error,
    output logic [2:0]       lights,
    output logic             lights_locked,
    output logic             seq_error,
    output logic [CNT_W-1:0] error_count
`ifdef RESULT_DECODER_SEG_EN
    ,
    output logic [6:0]       seg
`endif
);

    typedef enum logic [2:0] {
        ST_UNSYNC    = 3'd0,
        ST_RED       = 3'd1,
        ST_RED_AMBER = 3'd2,
        ST_GREEN     = 3'd3,
        ST_AMBER     = 3'd4
    } light_state_t;

    localparam logic [3:0]       STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Map a raw {red,amber,green} pattern to the state it represents;
    // anything that is not one of the four legal patterns maps to UNSYNC.
    function automatic light_state_t pattern_to_state(input logic [2:0] p);
        case (p)
            3'b100:  return ST_RED;
            3'b110:  return ST_RED_AMBER;
            3'b001:  return ST_GREEN;
            3'b010:  return ST_AMBER;
            default: return ST_UNSYNC;
        endcase
    endfunction

    function automatic light_state_t next_in_seq(input light_state_t s);
        case (s)
            ST_RED:       return ST_RED_AMBER;
            ST_RED_AMBER: return ST_GREEN;
            ST_GREEN:     return ST_AMBER;
            ST_AMBER:     return ST_RED;
            default:      return ST_UNSYNC;
        endcase
    endfunction

    function automatic logic [2:0] state_to_lights(input light_state_t s);
        case (s)
            ST_RED:       return 3'b100;
            ST_RED_AMBER: return 3'b110;
            ST_GREEN:     return 3'b001;
            ST_AMBER:     return 3'b010;
            default:      return 3'b000;
        endcase
    endfunction

    // Input register stage and history
    logic [2:0]   r_q;
    logic         sel_q;
    logic         sel_prev;     // sel_q of the previous cycle
    logic [2:0]   dice_prev;    // last dice-channel sample
    logic [3:0]   stab_cnt;
    light_state_t state;

    // Decision logic
    light_state_t pat_state;
    light_state_t eff_state;
    light_state_t light_next;
    logic         light_fault;
    logic [3:0]   stab_next;
    logic         qualify;
    logic         dice_legal;
    logic         dice_accept;
    logic         dice_fault;

    always_comb begin
        pat_state   = pattern_to_state(r_q);
        // Lights keep running while the dice channel is selected, so the
        // first light sample after a gap is a fresh acquisition.
        eff_state   = sel_prev ? state : ST_UNSYNC;
        light_next  = state;
        light_fault = 1'b0;
        if (sel_q) begin
            if (eff_state == ST_UNSYNC) begin
                light_next  = pat_state;
                light_fault = (pat_state == ST_UNSYNC);
            end else if ((pat_state == eff_state) ||
                         (pat_state == next_in_seq(eff_state))) begin
                light_next  = pat_state;
            end else begin
                light_next  = ST_UNSYNC;
                light_fault = 1'b1;
            end
        end
    end

    always_comb begin
        if (sel_q) begin
            stab_next = 4'd0;
        end else if ((r_q == dice_prev) && (stab_cnt != 4'd0)) begin
            stab_next = (stab_cnt == STABLE_MAX) ? STABLE_MAX : stab_cnt + 4'd1;
        end else begin
            stab_next = 4'd1;
        end
        // Fire only on the cycle the count reaches the threshold, so a
        // value held indefinitely produces a single pulse.
        qualify     = !sel_q && (stab_next == STABLE_MAX) && (stab_cnt != STABLE_MAX);
        dice_legal  = (r_q != 3'd0) && (r_q != 3'd7);
        dice_accept = qualify && dice_legal;
        dice_fault  = qualify && !dice_legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q           <= 3'd0;
            sel_q         <= 1'b0;
            sel_prev      <= 1'b0;
            dice_prev     <= 3'd0;
            stab_cnt      <= 4'd0;
            state         <= ST_UNSYNC;
            lights        <= 3'b000;
            lights_locked <= 1'b0;
            seq_error     <= 1'b0;
            dice_value    <= 3'd0;
            dice_strobe   <= 1'b0;
            dice_error    <= 1'b0;
            error_count   <= '0;
        end else begin
            r_q           <= result;
            sel_q         <= sel;
            sel_prev      <= sel_q;
            if (!sel_q) begin
                dice_prev <= r_q;
            end
            stab_cnt      <= stab_next;
            state         <= light_next;
            lights        <= state_to_lights(light_next);
            lights_locked <= (light_next != ST_UNSYNC);
            seq_error     <= light_fault;
            dice_strobe   <= dice_accept;
            dice_error    <= dice_fault;
            if (dice_accept) begin
                dice_value <= r_q;
            end
            // The two fault sources are exclusive: they need opposite sel_q.
            if ((light_fault || dice_fault) && (error_count != CNT_MAX)) begin
                error_count <= error_count + CNT_ONE;
            end
        end
    end

`ifdef RESULT_DECODER_SEG_EN
    function automatic logic [6:0] seg_encode(input logic [2:0] v);
        case (v)
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1011011;
            3'd3:    return 7'b1001111;
            3'd4:    return 7'b1100110;
            3'd5:    return 7'b1101101;
            3'd6:    return 7'b1111101;
            default: return 7'b0000000;
        endcase
    endfunction

    // Follows dice_value by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= 7'b0000000;
        end else begin
            seg <= seg_encode(dice_value);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_result_decoder
//  Purpose  : Self-checking bench for result_decoder. Directed stimulus; each
//             expected pulse (strobe / dice error / sequence error) is queued
//             with its value, counter and cycle, and a monitor matches every
//             pulse the DUT emits against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_decoder;

    localparam int STABLE  = 4;
    localparam int CNT_W   = 8;
    localparam int K_STROBE = 0;
    localparam int K_DERR   = 1;
    localparam int K_SEQ    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       result;
    logic             sel;
    logic [2:0]       dice_value;
    logic             dice_strobe;
    logic             dice_error;
    logic [2:0]       lights;
    logic             lights_locked;
    logic             seq_error;
    logic [CNT_W-1:0] error_count;
`ifdef RESULT_DECODER_SEG_EN
    logic [6:0]       seg;
`endif

    result_decoder #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .sel          (sel),
        .dice_value   (dice_value),
        .dice_strobe  (dice_strobe),
        .dice_error   (dice_error),
        .lights       (lights),
        .lights_locked(lights_locked),
        .seq_error    (seq_error),
        .error_count  (error_count)
`ifdef RESULT_DECODER_SEG_EN
        ,
        .seg          (seg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int value;
        int count;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input int kind, input int value, input int count,
                             input int offset);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.count = count;
        e.cyc   = cyc + offset;
        exp_q.push_back(e);
    endtask

    // Present a value from just after a rising edge for n rising edges.
    task automatic drive(input logic [2:0] v, input logic s, input int n);
        result = v;
        sel    = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        int  act_kind;
        int  act_val;
        ev_t e;
        if (rst && (dice_strobe || dice_error || seq_error)) begin
            check("pulse_onehot", $countones({dice_strobe, dice_error, seq_error}), 1);
            act_kind = dice_strobe ? K_STROBE : (dice_error ? K_DERR : K_SEQ);
            act_val  = (act_kind == K_SEQ) ? int'({lights_locked, lights}) : int'(dice_value);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse kind=%0d cyc=%0d expected=none", act_kind, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind",  act_kind,    e.kind);
                check("pulse_value", act_val,     e.value);
                check("pulse_count", error_count, e.count);
                check("pulse_cycle", cyc,         e.cyc);
            end
        end
    end

    initial begin
        rst    = 1'b0;
        result = 3'b100;
        sel    = 1'b1;
        #12;
        check("rst_dice_value", dice_value, 0);
        check("rst_pulses", {dice_strobe, dice_error, seq_error}, 0);
        check("rst_lights", lights, 0);
        check("rst_locked", lights_locked, 0);
        check("rst_count", error_count, 0);
`ifdef RESULT_DECODER_SEG_EN
        check("rst_seg", seg, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Legal light sequence
        drive(3'b100, 1'b1, 3); check("seq_red", lights, 3'b100);
        check("seq_locked", lights_locked, 1);
        drive(3'b110, 1'b1, 2); check("seq_red_amber", lights, 3'b110);
        drive(3'b001, 1'b1, 3); check("seq_green", lights, 3'b001);
        drive(3'b010, 1'b1, 2); check("seq_amber", lights, 3'b010);
        drive(3'b100, 1'b1, 2); check("seq_wrap_red", lights, 3'b100);
        check("seq_count", error_count, 0);

        // Illegal RED -> GREEN, then relock to GREEN
        drive(3'b100, 1'b1, 3);
        expect_ev(K_SEQ, 0, 1, 2);
        drive(3'b001, 1'b1, 2);
        check("illegal_unlocked", lights_locked, 0);
        check("illegal_lights", lights, 3'b000);
        drive(3'b001, 1'b1, 1);
        check("relock_green", lights, 3'b001);
        check("relock_locked", lights_locked, 1);

        // Channel switch: AMBER, dice gap, then RED_AMBER reacquired silently
        drive(3'b010, 1'b1, 2); check("switch_amber", lights, 3'b010);
        drive(3'd3, 1'b0, 2);   check("switch_hold", lights, 3'b010);
        drive(3'b110, 1'b1, 2); check("switch_reacq", lights, 3'b110);
        check("switch_locked", lights_locked, 1);
        check("switch_count", error_count, 1);

        // Dice accept
        expect_ev(K_STROBE, 5, 1, STABLE + 1);
        drive(3'd5, 1'b0, 10);
        check("accept_value", dice_value, 5);
`ifdef RESULT_DECODER_SEG_EN
        check("accept_seg", seg, 7'b1101101);
`endif

        // Illegal stable 7, short 3, then stable 4
        expect_ev(K_DERR, 5, 2, STABLE + 1);
        drive(3'd7, 1'b0, 4);
        drive(3'd3, 1'b0, 3);
        expect_ev(K_STROBE, 4, 2, STABLE + 1);
        drive(3'd4, 1'b0, 4);
        drive(3'd4, 1'b0, 2);
        check("unstable_value", dice_value, 4);
        check("unstable_count", error_count, 2);

        // Reset in the middle of a qualification
        drive(3'd2, 1'b0, 3);
        rst    = 1'b0;
        result = 3'b100;
        sel    = 1'b1;
        #1;
        check("midrst_dice_value", dice_value, 0);
        check("midrst_count", error_count, 0);
        check("midrst_lights", {lights_locked, lights}, 0);
        check("midrst_pulses", {dice_strobe, dice_error, seq_error}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(3'b100, 1'b1, 8);
        check("postrst_lights", lights, 3'b100);
        check("postrst_dice_value", dice_value, 0);

        // Saturation: 300 stable illegal throws alternating 7 and 0
        for (int i = 0; i < 300; i++) begin
            expect_ev(K_DERR, 0, (i + 1 > 255) ? 255 : i + 1, STABLE + 1);
            drive((i % 2 == 0) ? 3'd7 : 3'd0, 1'b0, 4);
        end
        drive(3'b100, 1'b1, 10);
        check("sat_count", error_count, 255);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_decoder.md
# result_decoder

Receive-side counterpart of the dice/traffic-light multiplexer. Takes the shared 3-bit `result` bus plus its `sel` line and demultiplexes it back into a validated dice channel and a validated traffic-light channel. Checks each channel against its legal protocol: dice values 1..6, and the light sequence red → red+amber → green → amber → red. Flags violations and counts them, so a bench or display stage downstream of the mux sees only clean, debounced data.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical dice samples required before a throw is accepted (legal range 2..15).
- `CNT_W`, 8: width of the saturating error counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `result` in 3: muxed bus. Dice value when `sel`=0; `{red,amber,green}` when `sel`=1.
- `sel` in 1: channel select, same meaning as at the mux.
- `dice_value` out 3: last accepted throw.
- `dice_strobe` out 1: one-cycle pulse when `dice_value` updates.
- `dice_error` out 1: one-cycle pulse when a stable illegal dice value (0 or 7) is seen.
- `lights` out 3: `{red,amber,green}` of the tracked light state; 000 while unlocked.
- `lights_locked` out 1: light FSM is synchronised to a legal sequence.
- `seq_error` out 1: one-cycle pulse on an illegal light pattern or transition.
- `error_count` out `CNT_W`: saturating count of `dice_error` + `seq_error` pulses.

## Operation
- Input stage: `result` and `sel` are registered every cycle into `r_q` / `sel_q`. All decisions use the registered copies.
- Legal light patterns: RED=100, RED_AMBER=110, GREEN=001, AMBER=010.
- Light FSM states: UNSYNC, RED, RED_AMBER, GREEN, AMBER. It is evaluated only on `sel_q`=1 cycles and holds otherwise.
  - UNSYNC: a legal pattern moves to the matching state. An illegal pattern stays in UNSYNC and pulses `seq_error`.
  - Locked state: the same pattern stays. The next pattern in sequence advances (AMBER→RED wraps). Anything else pulses `seq_error` and goes to UNSYNC.
  - First `sel_q`=1 cycle after any `sel_q`=0 cycle: the FSM is treated as UNSYNC. Lights run while deselected, so this reacquisition raises no error.
- Dice channel is evaluated only on `sel_q`=0 cycles and uses stability counter `stab_cnt` (4 bits).
  - `sel_q`=1: `stab_cnt`←0.
  - `sel_q`=0 and `r_q` equals the previous dice sample with `stab_cnt`≠0: `stab_cnt` increments, saturating at `STABLE_CYCLES`. Otherwise `stab_cnt`←1.
  - Cycle where `stab_cnt` becomes exactly `STABLE_CYCLES`:
    - `r_q` in 1..6: `dice_value`←`r_q` and `dice_strobe`=1.
    - Otherwise: `dice_error`=1 and `dice_value` is unchanged.
  - Result: exactly one pulse per stable period. A rolling dice (button held) produces no pulses.
- `error_count` adds 1 per error pulse and saturates at 2^`CNT_W`−1. `dice_error` and `seq_error` are mutually exclusive by construction.

## Timing
- Latency is 2 clocks from a `result`/`sel` change at the pins to the affected registered output (input register + decision register).
- Dice acceptance: `dice_strobe` asserts on the (`STABLE_CYCLES`+1)-th rising edge after the value first appears while `sel` is low.
- All outputs are registered. Pulses (`dice_strobe`, `dice_error`, `seq_error`) are exactly one clock wide.
- Reset (`rst`=0) asynchronously clears everything:
  - `dice_value`=0, all pulses=0, `lights`=000, `lights_locked`=0, `error_count`=0, `seg`=0.
  - FSM→UNSYNC; `stab_cnt`, `r_q` and `sel_q` → 0.
- Reset release is sampled on the rising edge; normal operation starts the following cycle.
- Reset mid-operation aborts any pending dice qualification. No strobe is emitted for a value that had not yet reached `STABLE_CYCLES`.

## Configuration
- `RESULT_DECODER_SEG_EN` defined: adds output `seg[6:0]` (`{g,f,e,d,c,b,a}`, active-high, registered from `dice_value`, so it updates 1 clock after `dice_strobe`).
  - 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101.
  - 0 → 0000000.
- Undefined: the `seg` port and its logic are absent; all other behaviour is identical.

## Test plan
- Light sequence: `sel`=1, drive 100×3, 110×2, 001×3, 010×2, 100×2 → `lights_locked`=1 from 2 clocks after start, `lights` tracks each pattern with 2-clock lag, `seq_error` never asserts, `error_count`=0.
- Illegal transition: `sel`=1, 100×3 then 001 → single `seq_error` pulse, `error_count`=1, `lights_locked` drops to 0, then relocks to GREEN one cycle later.
- Dice accept: `sel`=0, `result`=5 held 10 cycles → exactly one `dice_strobe`, 5 clocks after first sample edge. `dice_value`=5 afterwards; with SEG_EN, `seg`=1101101.
- Dice reject/unstable: `result`=7 held 4 → one `dice_error`, `dice_value` unchanged, `error_count`+1. Then 3×3 followed by 4×4 → only one strobe, with `dice_value`=4.
- Channel switch and reset: `sel` toggled 0→1 in mid-lights sequence → no `seq_error`. Assert `rst`=0 mid-dice-qualification → all outputs 0 immediately, no strobe after release.
- Saturation: 300 forced illegal dice throws → `error_count` stops at 255.
